hazard_ctrl_unit: RTL
=====================

# hazard_ctrl_unit

Parametrised pipeline control unit for the 5-stage RV32 core: merges load-use hazard detection, EX/WB forwarding select, branch/jump flush and a variable-latency data-memory wait into one block with a small FSM. Sits beside the datapath and drives the PC stall, IF/ID and ID/EX bubble/flush controls and the operand-forwarding muxes. Adds memory-latency freezing, a wait timeout and saturating performance counters, which the single-cycle-memory pipeline lacks.

## Interface
- RF_ADDR, 5, register index width
- FWD_EN, 1, 1 = EX/WB forwarding on; 0 = stall on every in-flight RAW
- MEM_TIMEOUT, 15, max dmem wait cycles before error (≥1)
- CNT_W, 16, performance counter width

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- id_rs1, id_rs2  in  RF_ADDR  source registers of instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd, mem_rd, wb_rd  in  RF_ADDR  destination in EX/MEM/WB
- ex_reg_write, mem_reg_write, wb_reg_write  in  1  stage writes rd
- ex_mem_read  in  1  EX instruction is a load
- ex_rs1, ex_rs2  in  RF_ADDR  sources of EX instruction (forwarding)
- ex_redirect  in  1  EX resolves taken branch/jal/jalr
- dmem_req  in  1  MEM stage issues load/store this cycle
- dmem_ack  in  1  data memory completes request
- pc_stall  out  1  hold PC and IF/ID
- ifid_flush  out  1  zero IF/ID next edge
- idex_bubble  out  1  load zeros (NOP) into ID/EX next edge
- freeze  out  1  hold every pipeline register, including EX/MEM and MEM/WB
- fwd_a_sel, fwd_b_sel  out  2  00 register file, 01 WB result, 10 MEM ALU result
- timeout_err  out  1  sticky dmem timeout
- stall_cycles, flush_count  out  CNT_W  saturating performance counters

## Operation
- Forwarding, with FWD_EN=1. For operand A: if mem_reg_write and mem_rd≠0 and mem_rd==ex_rs1, select 10. Otherwise, if wb_reg_write and wb_rd≠0 and wb_rd==ex_rs1, select 01. Otherwise select 00. Operand B is the same using ex_rs2. MEM has priority over WB. With FWD_EN=0, both selects are 00.
- A RAW match requires a nonzero rd, the stage's reg_write set, and id_use_rsN set.
- Load-use hazard, with FWD_EN=1: ex_mem_read and RAW(ex_rd) → pc_stall=1, idex_bubble=1.
- Any RAW hazard, with FWD_EN=0: a RAW match on ex_rd or mem_rd → the same stall. WB needs no stall because the register file writes before it reads.
- Redirect: ex_redirect → ifid_flush=1, idex_bubble=1, pc_stall=0. Redirect overrides a simultaneous load-use stall.
- FSM states are RUN, MEM_WAIT and ERR. State reset value is RUN.
- RUN → MEM_WAIT when dmem_req && !dmem_ack.
- MEM_WAIT → RUN on dmem_ack.
- MEM_WAIT → ERR when the wait counter reaches MEM_TIMEOUT without an ack.
- ERR is left only by reset.
- freeze = (dmem_req && !dmem_ack) in RUN or MEM_WAIT, and is 1 in ERR.
- While freeze=1: pc_stall=1, ifid_flush=0 and idex_bubble=0. A redirect is not acted on; it stays held in the frozen EX stage and is re-presented once freeze drops.
- Wait counter: cleared in RUN, incremented each MEM_WAIT cycle, and saturates at MEM_TIMEOUT.
- timeout_err=1 exactly while the FSM is in ERR.
- stall_cycles increments each cycle pc_stall=1.
- flush_count increments each cycle ifid_flush=1.
- Both counters saturate at all-ones.

## Timing
- Forward selects and stall, flush and bubble outputs are combinational from the inputs and the current state. Their effect lands at the next clk edge.
- FSM, wait counter and perf counters update on the clk edge.
- Load-use costs exactly 1 bubble with FWD_EN=1, and up to 2 bubbles with FWD_EN=0.
- Redirect costs 2 squashed instructions.
- A memory ack in the same cycle as the request means no freeze and no FSM transition.
- Reset, sampled at clk while rst_n=0:
  - state RUN, counters 0, timeout_err 0.
  - While rst_n is low the combinational outputs are forced to: ifid_flush=1, idex_bubble=1, pc_stall=0, freeze=0, fwd selects 00.
- Reset in MEM_WAIT or ERR returns to RUN on the next edge.

## Structure
- A shared riscv_package holds:
  - typedef enum logic [1:0] {HZ_RUN, HZ_MEM_WAIT, HZ_ERR} hz_state_e
  - typedef enum logic [1:0] {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10} fwd_sel_e
- One natural sub-module, fwd_select: a purely combinational single-operand comparator, instanced twice (A and B).
- The FSM, counters and stall arbitration live in the top.

## Test plan
- Forward priority: mem_rd=5 and wb_rd=5, both writing, ex_rs1=5 → fwd_a_sel=10. Same but mem_reg_write=0 → 01. Same but rd=0 → 00.
- Load-use: ex_mem_read=1, ex_rd=7, id_rs2=7, id_use_rs2=1 → pc_stall=1 and idex_bubble=1 for exactly one cycle, stall_cycles increments by 1. Same with id_use_rs2=0 → no stall.
- Redirect plus load-use in the same cycle → ifid_flush=1, idex_bubble=1, pc_stall=0, flush_count increments by 1.
- Memory wait: dmem_req held, ack on the 4th cycle → freeze=1 for 3 cycles, state RUN after the ack edge. A redirect asserted during the freeze yields ifid_flush=0 until freeze drops.
- Timeout: MEM_TIMEOUT=3, no ack → timeout_err=1 after 3 wait cycles and freeze stays 1. rst_n=0 for one edge → state RUN, timeout_err=0, counters 0.
- FWD_EN=0: ex_rd=3 writing, id_rs1=3 → stall. Then mem_rd=3 → stall. Then wb_rd=3 → no stall. fwd selects stay 00 throughout.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline-control types: hazard FSM states and operand-forwarding mux selects.
package riscv_package;

   typedef enum logic [1:0] {HZ_RUN, HZ_MEM_WAIT, HZ_ERR} hz_state_e;

   typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;

endpackage

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Single-operand forwarding comparator: picks MEM result over WB result over register file.
module fwd_select
   import riscv_package::*;
#(
   parameter int RF_ADDR = 5
) (
   input  logic [RF_ADDR-1:0] ex_rs,
   input  logic [RF_ADDR-1:0] mem_rd,
   input  logic               mem_reg_write,
   input  logic [RF_ADDR-1:0] wb_rd,
   input  logic               wb_reg_write,
   output fwd_sel_e           sel
);

   // The younger MEM result wins over WB; x0 is never forwarded.
   always_comb begin
      sel = FWD_RF;
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs)) begin
         sel = FWD_MEM;
      end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: load-use/RAW stalls, redirect flush, forwarding selects,
// data-memory wait freeze with timeout, and saturating stall/flush counters.
module hazard_ctrl_unit
   import riscv_package::*;
#(
   parameter int RF_ADDR     = 5,
   parameter bit FWD_EN      = 1'b1,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [RF_ADDR-1:0] id_rs1,
   input  logic [RF_ADDR-1:0] id_rs2,
   input  logic               id_use_rs1,
   input  logic               id_use_rs2,
   input  logic [RF_ADDR-1:0] ex_rd,
   input  logic [RF_ADDR-1:0] mem_rd,
   input  logic [RF_ADDR-1:0] wb_rd,
   input  logic               ex_reg_write,
   input  logic               mem_reg_write,
   input  logic               wb_reg_write,
   input  logic               ex_mem_read,
   input  logic [RF_ADDR-1:0] ex_rs1,
   input  logic [RF_ADDR-1:0] ex_rs2,
   input  logic               ex_redirect,
   input  logic               dmem_req,
   input  logic               dmem_ack,
   output logic               pc_stall,
   output logic               ifid_flush,
   output logic               idex_bubble,
   output logic               freeze,
   output logic [1:0]         fwd_a_sel,
   output logic [1:0]         fwd_b_sel,
   output logic               timeout_err,
   output logic [CNT_W-1:0]   stall_cycles,
   output logic [CNT_W-1:0]   flush_count
);

   localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   hz_state_e         state;
   logic [WAIT_W-1:0] wait_cnt;
   fwd_sel_e          fwd_a;
   fwd_sel_e          fwd_b;
   logic              raw_ex;
   logic              raw_mem;
   logic              hazard;
   logic              mem_busy;

   fwd_select #(.RF_ADDR(RF_ADDR)) u_fwd_a (
      .ex_rs         (ex_rs1),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .sel           (fwd_a)
   );

   fwd_select #(.RF_ADDR(RF_ADDR)) u_fwd_b (
      .ex_rs         (ex_rs2),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .sel           (fwd_b)
   );

   assign fwd_a_sel = (FWD_EN && rst_n) ? fwd_a : FWD_RF;
   assign fwd_b_sel = (FWD_EN && rst_n) ? fwd_b : FWD_RF;

   assign raw_ex  = ex_reg_write && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
   assign raw_mem = mem_reg_write && (mem_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == mem_rd)) || (id_use_rs2 && (id_rs2 == mem_rd)));

   // Without forwarding every in-flight producer ahead of WB must drain before ID may issue.
   assign hazard   = FWD_EN ? (ex_mem_read && raw_ex) : (raw_ex || raw_mem);
   assign mem_busy = dmem_req && !dmem_ack;

   // Freeze beats redirect (the branch waits in EX), redirect beats a stall.
   always_comb begin
      freeze      = 1'b0;
      pc_stall    = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (!rst_n) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if ((state == HZ_ERR) || mem_busy) begin
         freeze   = 1'b1;
         pc_stall = 1'b1;
      end else if (ex_redirect) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (hazard) begin
         pc_stall    = 1'b1;
         idex_bubble = 1'b1;
      end
   end

   // The ERR decision uses the pre-increment count, so ERR arrives on the edge the count hits the limit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= HZ_RUN;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            HZ_RUN: begin
               wait_cnt <= '0;
               if (mem_busy) begin
                  state <= HZ_MEM_WAIT;
               end
            end
            HZ_MEM_WAIT: begin
               if (dmem_ack) begin
                  state    <= HZ_RUN;
                  wait_cnt <= '0;
               end else begin
                  if (wait_cnt != WAIT_MAX) begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
                  if (wait_cnt >= WAIT_MAX - 1'b1) begin
                     state       <= HZ_ERR;
                     timeout_err <= 1'b1;
                  end
               end
            end
            HZ_ERR: begin
               timeout_err <= 1'b1;
            end
            default: begin
               state <= HZ_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (pc_stall && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
         if (ifid_flush && (flush_count != CNT_MAX)) begin
            flush_count <= flush_count + 1'b1;
         end
      end
   end

endmodule
